// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and default sizes for the program loader
package prog_loader_pkg;

  localparam int IW_DEF     = 9;
  localparam int DW_DEF     = 8;
  localparam int PC_W_DEF   = 10;
  localparam int DA_W_DEF   = 8;
  localparam int CYC_W_DEF  = 16;
  localparam int MAX_CYCLES_DEF = 'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_I  = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_LAUNCH  = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into instruction/data memory, launches the CPU and times its run
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DW    = DW_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int DA_W  = DA_W_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter logic [CYC_W-1:0] MAX_CYCLES = CYC_W'(MAX_CYCLES_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_go,
  input  logic [PC_W:0]    cfg_inst_count,
  input  logic [DA_W:0]    cfg_data_count,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [PC_W-1:0]  imem_addr,
  output logic [IW-1:0]    imem_wdata,
  output logic             dmem_we,
  output logic [DA_W-1:0]  dmem_addr,
  output logic [DW-1:0]    dmem_wdata,
  output logic             cpu_start,
  input  logic             cpu_done,
  output logic             busy,
  output logic             run_done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [PC_W:0] INST_LIM = {1'b1, {PC_W{1'b0}}};
  localparam logic [DA_W:0] DATA_LIM = {1'b1, {DA_W{1'b0}}};
  localparam logic [PC_W:0] INST_ONE = (PC_W+1)'(1);
  localparam logic [DA_W:0] DATA_ONE = (DA_W+1)'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  state_t state, state_nxt;

  logic [PC_W:0] inst_total, inst_idx, inst_sat;
  logic [DA_W:0] data_total, data_idx, data_sat;
  logic          accept, go, inst_last, data_last;

  assign inst_sat  = (cfg_inst_count > INST_LIM) ? INST_LIM : cfg_inst_count;
  assign data_sat  = (cfg_data_count > DATA_LIM) ? DATA_LIM : cfg_data_count;
  assign accept    = in_valid && in_ready;
  assign go        = load_go && (state == ST_IDLE || state == ST_DONE || state == ST_TIMEOUT);
  assign inst_last = ((inst_idx + INST_ONE) == inst_total);
  assign data_last = ((data_idx + DATA_ONE) == data_total);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (load_go) begin
          if (inst_sat != '0)      state_nxt = ST_LOAD_I;
          else if (data_sat != '0) state_nxt = ST_LOAD_D;
          else                     state_nxt = ST_LAUNCH;
        end
      end
      ST_LOAD_I: begin
        if (accept && inst_last)
          state_nxt = (data_total != '0) ? ST_LOAD_D : ST_LAUNCH;
      end
      ST_LOAD_D: begin
        if (accept && data_last) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: state_nxt = ST_RUN;
      ST_RUN: begin
        // done takes priority over a simultaneous timeout
        if (cpu_done)                      state_nxt = ST_DONE;
        else if (cycle_count == MAX_CYCLES) state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    run_done  = 1'b0;
    timeout   = 1'b0;
    cpu_start = 1'b1;
    unique case (state)
      ST_LOAD_I, ST_LOAD_D: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_LAUNCH: busy = 1'b1;
      ST_RUN: begin
        busy      = 1'b1;
        cpu_start = 1'b0;
      end
      ST_DONE:    run_done = 1'b1;
      ST_TIMEOUT: timeout  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      inst_total  <= '0;
      data_total  <= '0;
      inst_idx    <= '0;
      data_idx    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      cycle_count <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;

      if (go) begin
        inst_total  <= inst_sat;
        data_total  <= data_sat;
        inst_idx    <= '0;
        data_idx    <= '0;
        imem_addr   <= '0;
        dmem_addr   <= '0;
        cycle_count <= '0;
      end

      // write strobe/address/data are registered one cycle behind the accept
      if (state == ST_LOAD_I && accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= inst_idx[PC_W-1:0];
        imem_wdata <= in_data;
        inst_idx   <= inst_idx + INST_ONE;
      end

      if (state == ST_LOAD_D && accept) begin
        dmem_we    <= 1'b1;
        dmem_addr  <= data_idx[DA_W-1:0];
        dmem_wdata <= in_data[DW-1:0];
        data_idx   <= data_idx + DATA_ONE;
      end

      if (state == ST_RUN && !cpu_done && cycle_count != MAX_CYCLES)
        cycle_count <= cycle_count + CYC_ONE;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven and scoreboard bench for prog_loader
module tb_prog_loader;

  localparam int IW = 9, DW = 8, PC_W = 10, DA_W = 8, CYC_W = 16;
  localparam int MAXC = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load_go = 1'b0;
  logic [PC_W:0]    cfg_inst_count = '0;
  logic [DA_W:0]    cfg_data_count = '0;
  logic             in_valid = 1'b0;
  logic [IW-1:0]    in_data = '0;
  logic             in_ready;
  logic             imem_we;
  logic [PC_W-1:0]  imem_addr;
  logic [IW-1:0]    imem_wdata;
  logic             dmem_we;
  logic [DA_W-1:0]  dmem_addr;
  logic [DW-1:0]    dmem_wdata;
  logic             cpu_start;
  logic             cpu_done = 1'b0;
  logic             busy, run_done, timeout;
  logic [CYC_W-1:0] cycle_count;

  prog_loader #(
    .IW(IW), .DW(DW), .PC_W(PC_W), .DA_W(DA_W), .CYC_W(CYC_W),
    .MAX_CYCLES(CYC_W'(MAXC))
  ) dut (
    .clk(clk), .reset(reset), .load_go(load_go),
    .cfg_inst_count(cfg_inst_count), .cfg_data_count(cfg_data_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy),
    .run_done(run_done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t iq[$];
  wr_t dq[$];
  wr_t ie, de;
  int  iw_cnt = 0;
  int  dw_cnt = 0;

  // scoreboard: every observed write must match the oldest predicted one
  always @(negedge clk) begin
    if (imem_we) begin
      iw_cnt++;
      if (iq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL imem_spurious: write addr %0h data %0h, expected none", imem_addr, imem_wdata);
      end else begin
        ie = iq.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(ie.addr));
        check("imem_wdata", 32'(imem_wdata), 32'(ie.data));
        check("imem_cycle", 32'(cyc), 32'(ie.cyc));
      end
    end
    if (dmem_we) begin
      dw_cnt++;
      if (dq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dmem_spurious: write addr %0h data %0h, expected none", dmem_addr, dmem_wdata);
      end else begin
        de = dq.pop_front();
        check("dmem_addr", 32'(dmem_addr), 32'(de.addr));
        check("dmem_wdata", 32'(dmem_wdata), 32'(de.data));
        check("dmem_cycle", 32'(cyc), 32'(de.cyc));
      end
    end
  end

  logic [IW-1:0] words [6];

  typedef struct {
    int          icnt;
    int          dcnt;
    logic [15:0] vmask;
    int          done_at;
    logic        exp_done;
    logic        exp_to;
    int          exp_cc;
  } vec_t;

  vec_t vt [4];

  task automatic run_case(input vec_t v, input int id);
    int   idx = 0;
    int   k = 0;
    int   wi;
    int   total = v.icnt + v.dcnt;
    int   iw0 = iw_cnt;
    int   dw0 = dw_cnt;
    int   last;
    logic vld;
    @(negedge clk);
    load_go = 1'b1;
    cfg_inst_count = (PC_W+1)'(v.icnt);
    cfg_data_count = (DA_W+1)'(v.dcnt);
    @(negedge clk);
    load_go = 1'b0;
    check($sformatf("c%0d_cc_cleared", id), 32'(cycle_count), 32'd0);
    check($sformatf("c%0d_busy_load", id), 32'(busy), 32'd1);
    while (idx < total) begin
      vld = (k >= 16) ? 1'b1 : v.vmask[k];
      wi = idx % 6;
      in_valid = vld;
      in_data = words[wi];
      check($sformatf("c%0d_in_ready_k%0d", id, k), 32'(in_ready), 32'd1);
      if (vld) begin
        if (idx < v.icnt) iq.push_back('{idx, int'(words[wi]), cyc + 1});
        else dq.push_back('{idx - v.icnt, int'(words[wi][7:0]), cyc + 1});
        idx++;
      end
      k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check($sformatf("c%0d_launch_in_ready", id), 32'(in_ready), 32'd0);
    check($sformatf("c%0d_launch_cpu_start", id), 32'(cpu_start), 32'd1);
    check($sformatf("c%0d_launch_busy", id), 32'(busy), 32'd1);
    @(negedge clk);
    check($sformatf("c%0d_run_cpu_start", id), 32'(cpu_start), 32'd0);
    last = (v.done_at > 0) ? v.done_at : MAXC + 1;
    for (int r = 1; r <= last; r++) begin
      cpu_done = (r == v.done_at);
      @(negedge clk);
    end
    cpu_done = 1'b0;
    check($sformatf("c%0d_run_done", id), 32'(run_done), 32'(v.exp_done));
    check($sformatf("c%0d_timeout", id), 32'(timeout), 32'(v.exp_to));
    check($sformatf("c%0d_cycle_count", id), 32'(cycle_count), 32'(v.exp_cc));
    check($sformatf("c%0d_end_cpu_start", id), 32'(cpu_start), 32'd1);
    check($sformatf("c%0d_end_busy", id), 32'(busy), 32'd0);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    check($sformatf("c%0d_cc_frozen", id), 32'(cycle_count), 32'(v.exp_cc));
    check($sformatf("c%0d_run_done_hold", id), 32'(run_done), 32'(v.exp_done));
    check($sformatf("c%0d_imem_writes", id), 32'(iw_cnt - iw0), 32'(v.icnt));
    check($sformatf("c%0d_dmem_writes", id), 32'(dw_cnt - dw0), 32'(v.dcnt));
  endtask

  initial begin
    words[0] = 9'h101; words[1] = 9'h0A2; words[2] = 9'h1FF;
    words[3] = 9'h003; words[4] = 9'h155; words[5] = 9'h0AA;

    vt[0] = '{4, 2, 16'hFFFF, 10, 1'b1, 1'b0, 9};
    vt[1] = '{2, 0, 16'h0005, 0,  1'b0, 1'b1, MAXC};
    vt[2] = '{0, 0, 16'hFFFF, 1,  1'b1, 1'b0, 0};
    vt[3] = '{1, 1, 16'h0006, 3,  1'b1, 1'b0, 2};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_cpu_start", 32'(cpu_start), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_run_done", 32'(run_done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    reset = 1'b1;

    // reset in the middle of instruction loading
    @(negedge clk);
    load_go = 1'b1;
    cfg_inst_count = (PC_W+1)'(4);
    cfg_data_count = (DA_W+1)'(2);
    @(negedge clk);
    load_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = words[i];
      iq.push_back('{i, int'(words[i]), cyc + 1});
      @(negedge clk);
    end
    in_data = words[3];
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_imem_we", 32'(imem_we), 32'd0);
    check("midrst_cpu_start", 32'(cpu_start), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("postrst_in_ready_%0d", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrst_imem_writes", 32'(iw_cnt), 32'd3);

    for (int c = 0; c < 4; c++) run_case(vt[c], c);

    check("imem_queue_empty", 32'(iq.size()), 32'd0);
    check("dmem_queue_empty", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
